// File: rtl/chop_digits_arbiter_if.sv
// chop_digits_arbiter_if: requester handshake and datapath strobes shared with the digit arbiter
interface chop_digits_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  base_in;
  logic             number_is_0;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic             error;
  logic             busy;
  logic             get_new;
  logic             load_number;
  logic             load_index;
  logic             select_base;
  logic             write;
  logic [CNT_W-1:0] digit_count;
  modport master (
    output req, base_in, number_is_0,
    input  grant, done, error, busy, get_new, load_number, load_index, select_base, write, digit_count
  );
  modport slave (
    input  req, base_in, number_is_0,
    output grant, done, error, busy, get_new, load_number, load_index, select_base, write, digit_count
  );
endinterface

// File: rtl/chop_digits_arbiter.sv
// chop_digits_arbiter: round-robin owner of one chopUpDigits datapath, sequencing its digit loop
module chop_digits_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_DIGITS = 11,
  parameter int CNT_W      = 4
) (
  input logic                 i_clk,
  input logic                 i_reset,
  chop_digits_arbiter_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_DIGITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_LOOP, S_WRITE, S_FINISH} state_t;

  state_t           r_state, w_state_n;
  logic [IW-1:0]    r_owner, w_owner_n, r_ptr, w_ptr_n, w_pick, w_idx;
  logic             r_base, w_base_n, r_err, w_err_n, w_any, w_limit;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [NREQ-1:0]  w_onehot;

  assign w_limit = r_cnt == MAXC;

  // first requesting index after the last owner, wrapping; smallest offset wins
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (bus.req[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  // next state and job context; context only changes on a new grant or in the loop
  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_base_n  = r_base;
    w_err_n   = r_err;
    w_cnt_n   = r_cnt;
    case (r_state)
      S_IDLE: if (w_any) begin
        w_state_n = S_START;
        w_owner_n = w_pick;
        w_ptr_n   = w_pick;
        w_base_n  = bus.base_in[w_pick];
        w_cnt_n   = '0;
        w_err_n   = 1'b0;
      end
      S_START: w_state_n = S_LOOP;
      S_LOOP: begin
        w_err_n   = !bus.number_is_0 && w_limit;
        w_state_n = (bus.number_is_0 || w_limit) ? S_FINISH : S_WRITE;
      end
      S_WRITE: begin
        w_state_n = S_LOOP;
        w_cnt_n   = w_limit ? r_cnt : r_cnt + 1'b1;
      end
      S_FINISH: w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // state and context registers; reset aborts any job without a done
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= IW'(NREQ - 1);
      r_base  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_base  <= w_base_n;
      r_err   <= w_err_n;
      r_cnt   <= w_cnt_n;
    end
  end

  assign w_onehot        = NREQ'(1) << r_owner;
  assign bus.grant       = r_state != S_IDLE ? w_onehot : '0;
  assign bus.done        = r_state == S_FINISH ? w_onehot : '0;
  assign bus.error       = r_state == S_FINISH && r_err;
  assign bus.busy        = r_state != S_IDLE;
  assign bus.get_new     = r_state == S_START;
  assign bus.load_number = r_state == S_START || r_state == S_WRITE;
  assign bus.load_index  = r_state == S_START || r_state == S_WRITE;
  assign bus.write       = r_state == S_WRITE;
  assign bus.select_base = r_base;
  assign bus.digit_count = r_cnt;
endmodule
